// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path (and the matching
//   transmitter): the receiver FSM state encoding and the baud-rate
//   divisor arithmetic, so both directions agree on clocks per bit.
//
//   Contents:
//     uart_state_t  - receiver FSM states
//     clks_per_bit  - rounded clk cycles per serial bit
package uart_pkg;

  // PARITY is always part of the encoding so the state numbering stays
  // identical whether or not the parity build option is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  // Round to nearest rather than truncate so the accumulated bit-timing
  // error over a frame stays within half a clock per bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on 'head' while the FIFO is non-empty; 'pop' consumes it.
//   A push into a full FIFO is only accepted when a pop frees a slot in
//   the same cycle; otherwise it is ignored (the caller reports the drop).
//
//   Parameters:
//     WIDTH  - entry width in bits
//     DEPTH  - number of entries, power of 2, at least 2
//
//   Ports:
//     clk        in   system clock
//     resetn     in   synchronous active-low reset (pointers, count)
//     push       in   write push_data this cycle
//     push_data  in   WIDTH  data to write
//     pop        in   consume head entry (ignored when empty)
//     head       out  WIDTH  oldest entry, 0 when empty
//     full       out  FIFO holds DEPTH entries
//     empty      out  FIFO holds no entries
//     count      out  $clog2(DEPTH)+1  current occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Returning 0 when empty keeps the output quiet and gives a defined
  // value straight out of reset even though the storage is not reset.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage array, kept free of reset so it maps onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver (8 data bits, LSB first, 1 stop bit) feeding a small
//   first-word-fall-through byte FIFO with a valid/ready consumer port.
//   Used to bring host characters and debug commands into the design.
//
//   Build option:
//     UART_RX_PARITY_EN - when defined, an even-parity bit is expected
//                         between the data bits and the stop bit; bytes
//                         with a parity mismatch are dropped and
//                         parity_err pulses. When undefined the frame is
//                         10 bits and parity_err is tied to 0.
//
//   Parameters:
//     CLK_FREQ    - clk frequency in Hz
//     BAUD        - serial line rate
//     FIFO_DEPTH  - FIFO entries, power of 2, at least 2
//
//   Ports:
//     clk         in   system clock
//     resetn      in   synchronous active-low reset
//     uart_rx     in   serial line, idle high, asynchronous to clk
//     rx_data     out  8  FIFO head byte, valid when rx_valid=1
//     rx_valid    out  FIFO non-empty
//     rx_ready    in   consumer takes head byte when rx_valid && rx_ready
//     fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//     frame_err   out  one-cycle pulse, stop bit sampled low
//     overflow    out  one-cycle pulse, received byte dropped (FIFO full)
//     parity_err  out  one-cycle pulse, parity mismatch
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          parity_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);

  // The timer counts down to 0 and the sample is taken on the zero cycle,
  // so each wait of N clocks loads N-1.
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_hist;
  logic [1:0]    settle;
  logic          fall;

  uart_state_t   state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_byte;

  logic          fifo_full;
  logic          fifo_empty;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  // The synchronizer resets to idle-high, but those reset values are not
  // real line samples: if the line is still low when reset releases they
  // would look like a falling edge. The history flop is therefore held at
  // 0 until two clocks after reset, when rx_sync carries a genuine sample,
  // so a line that is already low needs to go high before a start counts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_hist <= 1'b0;
      settle  <= 2'b00;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      settle  <= {settle[0], 1'b1};
      rx_hist <= rx_sync && settle[1];
    end
  end

  assign fall = rx_hist && !rx_sync;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Byte is pushed straight from the stop-bit sample so it is visible on
  // rx_data the following cycle.
`ifdef UART_RX_PARITY_EN
  assign push_byte = (state == ST_STOP) && (timer == '0) && rx_sync && !par_bad;
`else
  assign push_byte = (state == ST_STOP) && (timer == '0) && rx_sync;
`endif

  // Receiver FSM. Every state entry reloads the bit timer. START waits
  // half a bit so that all later full-bit waits land mid-bit. The FSM
  // leaves STOP at the stop-bit midpoint so a start edge arriving half a
  // bit later is still caught. A stop bit sampled low is treated as a
  // break: one frame_err, then wait for the line to return high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            timer <= HALF_LOAD;
          end
        end

        ST_START: begin
          if (timer == '0) begin
            if (rx_sync) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              timer   <= FULL_LOAD;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_DATA: begin
          if (timer == '0) begin
            shreg <= {rx_sync, shreg[7:1]};
            timer <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        ST_PARITY: begin
          if (timer == '0) begin
            state <= ST_STOP;
            timer <= FULL_LOAD;
            if (rx_sync != (^shreg)) begin
              parity_err <= 1'b1;
              par_bad    <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (timer == '0) begin
            if (rx_sync) begin
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_BREAK: begin
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A push into a full FIFO is only lost when no pop frees a slot in the
  // same cycle; that loss is reported alongside the push timing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_byte && fifo_full && !(rx_ready && !fifo_empty);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_byte),
    .push_data (shreg),
    .pop       (rx_ready),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Bench for uart_rx_fifo at the default 12 MHz / 115200 baud setting
//   (104 clocks per bit, 52 for the half-bit start check). Serial frames
//   are driven on uart_rx; each frame schedules its outcome (byte pushed,
//   frame error, parity error) at the clock edge where the stop bit is
//   judged. A queue model of the FIFO tracks what the outputs must be.
//
//   Timing of a frame whose start bit is driven just after edge c:
//     2 synchronizer edges + 1 edge to enter START  -> START at edge c+3
//     half-bit wait 52, then 8 data (+1 parity) bits of 104 each,
//     stop bit judged at edge c+3+52+9*104 = c+991 (c+1095 with parity).
module tb_uart_rx_fifo;

  localparam int CPB   = 104;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 1095;
  localparam int PAR_OFS  = 991;
`else
  localparam int STOP_OFS = 991;
  localparam int PAR_OFS  = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overflow;
  logic       parity_err;

  uart_rx_fifo #(
    .CLK_FREQ   (12000000),
    .BAUD       (115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rdy_s = 1'b0;
  logic rst_s = 1'b0;

  // Scheduled outcomes, keyed by the clock edge at which they take effect.
  logic [7:0] ev_push [int];
  bit         ev_ferr [int];
  bit         ev_perr [int];

  logic [7:0] q [$];
  logic [7:0] got [$];
  int   valid_cnt = 0;
  int   last_valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  int   ferr_cnt = 0;
  int   ovf_cnt = 0;
  int   perr_cnt = 0;

  bit   rand_mode = 1'b0;
  int   pulse_edge = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Edge counter and the input values the DUT sees at each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_s <= rx_ready;
    rst_s <= resetn;
  end

  // Model update for the edge just taken, then comparison of all outputs.
  always @(negedge clk) begin : compare
    bit pop_m;
    bit exp_ovf;
    bit exp_ferr;
    bit exp_perr;
    if (cyc > 0) begin
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      exp_perr = 1'b0;
      if (!rst_s) begin
        q.delete();
      end else begin
        pop_m = rdy_s && (q.size() > 0);
        if (pop_m) void'(q.pop_front());
        if (ev_push.exists(cyc)) begin
          if (q.size() < DEPTH) q.push_back(ev_push[cyc]);
          else exp_ovf = 1'b1;
        end
        exp_ferr = ev_ferr.exists(cyc);
        exp_perr = ev_perr.exists(cyc);
      end
      checkOutput("rx_valid", int'(rx_valid), int'(q.size() > 0));
      checkOutput("fifo_count", int'(fifo_count), q.size());
      if (q.size() > 0) checkOutput("rx_data", int'(rx_data), int'(q[0]));
      else if (!rst_s) checkOutput("rx_data_reset", int'(rx_data), 0);
      checkOutput("frame_err", int'(frame_err), int'(exp_ferr));
      checkOutput("overflow", int'(overflow), int'(exp_ovf));
      checkOutput("parity_err", int'(parity_err), int'(exp_perr));

      if (rx_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        last_data = rx_data;
      end
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (parity_err) perr_cnt++;
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
    if (pulse_edge > 0) begin
      if (cyc == pulse_edge - 1) rx_ready = 1'b1;
      else if (cyc == pulse_edge) rx_ready = 1'b0;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  // Drive one serial frame and schedule its expected outcome. Leaves the
  // line at the stop-bit level when it returns.
  task automatic applyStimulus(input logic [7:0] d, input bit stop, input bit bad_par,
                               input bit pop_at_stop);
    int  c;
    bit  pbad;
    c = cyc;
`ifdef UART_RX_PARITY_EN
    pbad = bad_par;
`else
    pbad = 1'b0;
    if (bad_par) $display("[TB] note: parity request ignored in this build");
`endif
    if (pbad) ev_perr[c + PAR_OFS] = 1'b1;
    if (!stop) ev_ferr[c + STOP_OFS] = 1'b1;
    else if (!pbad) ev_push[c + STOP_OFS] = d;
    if (pop_at_stop) pulse_edge = c + STOP_OFS;

    uart_rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      waitCycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ pbad;
    waitCycles(CPB);
`endif
    uart_rx = stop;
    waitCycles(CPB);
  endtask

  initial begin
    int         c0;
    logic [7:0] d;
    bit         stp;
    bit         bp;

    resetn   = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    waitCycles(5);
    checkOutput("reset_fifo_count", int'(fifo_count), 0);
    checkOutput("reset_rx_valid", int'(rx_valid), 0);
    resetn = 1'b1;
    waitCycles(20);

    // Single byte, consumer always ready: valid for exactly one cycle.
    $display("[TB] single byte 0x55");
    rx_ready = 1'b1;
    valid_cnt = 0; ferr_cnt = 0; perr_cnt = 0;
    c0 = cyc;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("t1_valid_cycles", valid_cnt, 1);
    checkOutput("t1_valid_edge", last_valid_cyc - c0, STOP_OFS);
    checkOutput("t1_data", int'(last_data), 8'h55);
    checkOutput("t1_ferr", ferr_cnt, 0);
    checkOutput("t1_perr", perr_cnt, 0);

    // Short glitch must be rejected and the receiver ready again promptly.
    $display("[TB] 20-clock glitch");
    valid_cnt = 0; ferr_cnt = 0;
    uart_rx = 1'b0;
    waitCycles(20);
    uart_rx = 1'b1;
    waitCycles(40);
    checkOutput("t2_glitch_valid", valid_cnt, 0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("t2_after_glitch_valid", valid_cnt, 1);
    checkOutput("t2_after_glitch_data", int'(last_data), 8'hC3);
    checkOutput("t2_ferr", ferr_cnt, 0);

    // Bad stop bit followed by a long break, then a normal byte.
    $display("[TB] framing error and break");
    valid_cnt = 0; ferr_cnt = 0;
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
    waitCycles(2000);
    uart_rx = 1'b1;
    waitCycles(50);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("t3_ferr_pulses", ferr_cnt, 1);
    checkOutput("t3_valid", valid_cnt, 1);
    checkOutput("t3_data", int'(last_data), 8'h3C);

    // Fill beyond capacity with the consumer stalled.
    $display("[TB] overflow");
    rx_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("t4_count_full", int'(fifo_count), 16);
    checkOutput("t4_overflow_pulses", ovf_cnt, 1);

    // Pop on the exact push cycle of a full FIFO: no drop.
    $display("[TB] push and pop when full");
    got.delete();
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b1);
    waitCycles(20);
    checkOutput("t5_count_full", int'(fifo_count), 16);
    checkOutput("t5_overflow_pulses", ovf_cnt, 1);
    rx_ready = 1'b1;
    waitCycles(40);
    checkOutput("t5_drain_len", got.size(), 17);
    if (got.size() == 17) begin
      for (int i = 0; i < 16; i++) checkOutput("t5_drain_order", int'(got[i]), i);
      checkOutput("t5_drain_last", int'(got[16]), 8'h77);
    end
    checkOutput("t5_empty_after", int'(fifo_count), 0);

    // Reset in the middle of a frame while the line is low.
    $display("[TB] reset mid-frame");
    valid_cnt = 0; ferr_cnt = 0;
    uart_rx = 1'b0;
    waitCycles(CPB);
    uart_rx = 1'b1;
    waitCycles(2 * CPB + 30);
    uart_rx = 1'b0;
    waitCycles(10);
    resetn = 1'b0;
    waitCycles(3);
    resetn = 1'b1;
    waitCycles(100);
    uart_rx = 1'b1;
    waitCycles(300);
    checkOutput("t6_no_false_byte", valid_cnt, 0);
    checkOutput("t6_no_ferr", ferr_cnt, 0);
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
    waitCycles(20);
    checkOutput("t6_valid", valid_cnt, 1);
    checkOutput("t6_data", int'(last_data), 8'h81);
`ifdef UART_RX_PARITY_EN
    perr_cnt = 0;
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
    waitCycles(20);
    checkOutput("t6_parity_pulses", perr_cnt, 1);
    checkOutput("t6_parity_no_push", valid_cnt, 1);
`endif

    // Random bytes, random stop bits and random consumer back-pressure.
    $display("[TB] random traffic");
    rand_mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      bp  = ($urandom_range(0, 3) == 0);
`else
      bp  = 1'b0;
`endif
      applyStimulus(d, stp, bp, 1'b0);
      if (!stp) begin
        waitCycles($urandom_range(50, 300));
        uart_rx = 1'b1;
      end
      waitCycles($urandom_range(5, 40));
    end
    rand_mode = 1'b0;
    rx_ready = 1'b1;
    waitCycles(100);
    checkOutput("final_empty", int'(fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
